trap_ctrl: RTL and testbench

- Trap sequencer directly downstream of the CSR block's interrupt outputs and upstream of its trap access channel.
- Accepts synchronous exceptions (ecall, ebreak, illegal instruction), masked interrupt requests and mret from the execute/writeback stage.
- Performs the machine-mode CSR save/restore sequence one write per cycle over the single trap CSR port.
- Issues a one-cycle redirect to the trap vector or to mepc while holding the pipeline.

---
 rtl/trap_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// Takes exceptions, masked interrupts and mret from the retire stage,
// performs the CSR save/restore sequence one write per cycle over the single
// trap CSR port, then issues a one-cycle redirect while holding the pipeline.
module trap_ctrl #(
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MTVEC   = 12'h305,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342,
    parameter logic [11:0] CSR_MTVAL   = 12'h343
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hx_valid_i,
    input  logic [31:0] inst_pc_i,
    input  logic [31:0] next_pc_i,
    input  logic [31:0] inst_i,
    input  logic        inst_ecall_i,
    input  logic        inst_ebreak_i,
    input  logic        inst_illegal_i,
    input  logic        inst_mret_i,
    input  logic        ex_trap_valid_i,
    input  logic        tcmp_trap_valid_i,
    input  logic        soft_trap_valid_i,
    input  logic        mstatus_MIE3_i,
    input  logic [31:0] mepc_i,
    output logic        trap_csr_we_o,
    output logic [11:0] trap_csr_addr_o,
    output logic [31:0] trap_csr_wdata_o,
    input  logic [31:0] trap_csr_rdata_i,
    output logic        trap_stall_o,
    output logic        trap_jump_o,
    output logic [31:0] trap_jump_addr_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MTVAL   = 3'd3,
        ST_W_MSTATUS = 3'd4,
        ST_T_JUMP    = 3'd5,
        ST_M_MSTATUS = 3'd6,
        ST_M_JUMP    = 3'd7
    } state_e;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_M_SOFT  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;

    // Trap entry: MPIE takes the old MIE, MIE is cleared.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] cur);
        logic [31:0] res;
        res    = cur;
        res[7] = cur[3];
        res[3] = 1'b0;
        return res;
    endfunction

    // mret: MIE restored from MPIE, MPIE set.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] cur);
        logic [31:0] res;
        res    = cur;
        res[3] = cur[7];
        res[7] = 1'b1;
        return res;
    endfunction

    // Trap target: direct base, or vectored offset for interrupts in mode 01.
    function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                                input logic [31:0] cause);
        logic [31:0] base;
        base = tvec & 32'hFFFF_FFFC;
        if (cause[31] && (tvec[1:0] == 2'b01)) begin
            return base + ((cause & 32'h7FFF_FFFF) << 2);
        end else begin
            return base;
        end
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q,   epc_d;
    logic [31:0] tval_q,  tval_d;

    logic        exc_s;
    logic        irq_s;
    logic        idle_s;
    logic        accept_trap_s;
    logic        accept_mret_s;

    // Qualify incoming events; only an IDLE cycle with a retiring instruction accepts.
    always_comb begin
        idle_s        = (state_q == ST_IDLE);
        exc_s         = inst_illegal_i | inst_ebreak_i | inst_ecall_i;
        irq_s         = ex_trap_valid_i | soft_trap_valid_i | tcmp_trap_valid_i;
        accept_trap_s = idle_s & hx_valid_i &
                        (exc_s | (~inst_mret_i & mstatus_MIE3_i & irq_s));
        accept_mret_s = idle_s & hx_valid_i & ~exc_s & inst_mret_i;
    end

    // State and trap context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cause_q <= 32'd0;
            epc_q   <= 32'd0;
            tval_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end

    // Next-state logic and capture of cause/epc/tval at accept.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_trap_s) begin
                    state_d = ST_W_MEPC;
                    if (inst_illegal_i) begin
                        cause_d = CAUSE_ILLEGAL;
                        tval_d  = inst_i;
                        epc_d   = inst_pc_i;
                    end else if (inst_ebreak_i) begin
                        cause_d = CAUSE_EBREAK;
                        tval_d  = inst_pc_i;
                        epc_d   = inst_pc_i;
                    end else if (inst_ecall_i) begin
                        cause_d = CAUSE_ECALL;
                        tval_d  = 32'd0;
                        epc_d   = inst_pc_i;
                    end else if (ex_trap_valid_i) begin
                        cause_d = CAUSE_M_EXT;
                        tval_d  = 32'd0;
                        epc_d   = next_pc_i;
                    end else if (soft_trap_valid_i) begin
                        cause_d = CAUSE_M_SOFT;
                        tval_d  = 32'd0;
                        epc_d   = next_pc_i;
                    end else begin
                        cause_d = CAUSE_M_TIMER;
                        tval_d  = 32'd0;
                        epc_d   = next_pc_i;
                    end
                end else if (accept_mret_s) begin
                    state_d = ST_M_MSTATUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_W_MEPC:    state_d = ST_W_MCAUSE;
            ST_W_MCAUSE:  state_d = ST_W_MTVAL;
            ST_W_MTVAL:   state_d = ST_W_MSTATUS;
            ST_W_MSTATUS: state_d = ST_T_JUMP;
            ST_T_JUMP:    state_d = ST_IDLE;
            ST_M_MSTATUS: state_d = ST_M_JUMP;
            ST_M_JUMP:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output decode: CSR port driven from the current state, stall also covers the accept cycle.
    always_comb begin
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = 12'd0;
        trap_csr_wdata_o = 32'd0;
        trap_jump_o      = 1'b0;
        trap_jump_addr_o = 32'd0;
        trap_stall_o     = ~idle_s | accept_trap_s | accept_mret_s;
        case (state_q)
            ST_W_MEPC: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MEPC;
                trap_csr_wdata_o = epc_q;
            end
            ST_W_MCAUSE: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MCAUSE;
                trap_csr_wdata_o = cause_q;
            end
            ST_W_MTVAL: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MTVAL;
                trap_csr_wdata_o = tval_q;
            end
            ST_W_MSTATUS: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = trap_mstatus(trap_csr_rdata_i);
            end
            ST_T_JUMP: begin
                trap_csr_addr_o  = CSR_MTVEC;
                trap_jump_o      = 1'b1;
                trap_jump_addr_o = trap_target(trap_csr_rdata_i, cause_q);
            end
            ST_M_MSTATUS: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = mret_mstatus(trap_csr_rdata_i);
            end
            ST_M_JUMP: begin
                trap_jump_o      = 1'b1;
                trap_jump_addr_o = mepc_i & 32'hFFFF_FFFC;
            end
            default: begin
                trap_csr_we_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scoreboard bench for trap_ctrl.
// Stimulus pushes expected CSR writes / jumps; a negedge monitor pops and compares.
module tb_trap_ctrl;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef struct packed {
        logic        jump;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        hx_valid_i;
    logic [31:0] inst_pc_i;
    logic [31:0] next_pc_i;
    logic [31:0] inst_i;
    logic        inst_ecall_i, inst_ebreak_i, inst_illegal_i, inst_mret_i;
    logic        ex_trap_valid_i, tcmp_trap_valid_i, soft_trap_valid_i;
    logic        mstatus_MIE3_i;
    logic [31:0] mepc_i;
    logic        trap_csr_we_o;
    logic [11:0] trap_csr_addr_o;
    logic [31:0] trap_csr_wdata_o;
    logic [31:0] trap_csr_rdata_i;
    logic        trap_stall_o;
    logic        trap_jump_o;
    logic [31:0] trap_jump_addr_o;

    logic [31:0] csr_mstatus;
    logic [31:0] csr_mtvec;

    exp_t exp_q[$];
    int   total;
    int   bad;

    trap_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hx_valid_i        (hx_valid_i),
        .inst_pc_i         (inst_pc_i),
        .next_pc_i         (next_pc_i),
        .inst_i            (inst_i),
        .inst_ecall_i      (inst_ecall_i),
        .inst_ebreak_i     (inst_ebreak_i),
        .inst_illegal_i    (inst_illegal_i),
        .inst_mret_i       (inst_mret_i),
        .ex_trap_valid_i   (ex_trap_valid_i),
        .tcmp_trap_valid_i (tcmp_trap_valid_i),
        .soft_trap_valid_i (soft_trap_valid_i),
        .mstatus_MIE3_i    (mstatus_MIE3_i),
        .mepc_i            (mepc_i),
        .trap_csr_we_o     (trap_csr_we_o),
        .trap_csr_addr_o   (trap_csr_addr_o),
        .trap_csr_wdata_o  (trap_csr_wdata_o),
        .trap_csr_rdata_i  (trap_csr_rdata_i),
        .trap_stall_o      (trap_stall_o),
        .trap_jump_o       (trap_jump_o),
        .trap_jump_addr_o  (trap_jump_addr_o)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational CSR read model.
    always_comb begin
        if (trap_csr_addr_o == A_MSTATUS) begin
            trap_csr_rdata_i = csr_mstatus;
        end else if (trap_csr_addr_o == A_MTVEC) begin
            trap_csr_rdata_i = csr_mtvec;
        end else begin
            trap_csr_rdata_i = 32'd0;
        end
    end

    // Monitor: every write or jump the DUT presents must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (trap_csr_we_o || trap_jump_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_txn: got jump=%0b we=%0b addr=%h data=%h, required none",
                         trap_jump_o, trap_csr_we_o, trap_csr_addr_o,
                         trap_jump_o ? trap_jump_addr_o : trap_csr_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if (trap_jump_o !== e.jump || trap_csr_we_o !== !e.jump ||
                    trap_csr_addr_o !== e.addr ||
                    (e.jump ? trap_jump_addr_o : trap_csr_wdata_o) !== e.data) begin
                    bad++;
                    $display("FAIL txn: got jump=%0b we=%0b addr=%h data=%h, required jump=%0b addr=%h data=%h",
                             trap_jump_o, trap_csr_we_o, trap_csr_addr_o,
                             trap_jump_o ? trap_jump_addr_o : trap_csr_wdata_o,
                             e.jump, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_w(input logic [11:0] a, input logic [31:0] d);
        exp_q.push_back('{jump: 1'b0, addr: a, data: d});
    endtask

    task automatic push_j(input logic [11:0] a, input logic [31:0] d);
        exp_q.push_back('{jump: 1'b1, addr: a, data: d});
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] tval, input logic [31:0] mst,
                             input logic [31:0] tgt);
        push_w(A_MEPC, epc);
        push_w(A_MCAUSE, cause);
        push_w(A_MTVAL, tval);
        push_w(A_MSTATUS, mst);
        push_j(A_MTVEC, tgt);
    endtask

    task automatic clear_in();
        hx_valid_i        = 1'b0;
        inst_ecall_i      = 1'b0;
        inst_ebreak_i     = 1'b0;
        inst_illegal_i    = 1'b0;
        inst_mret_i       = 1'b0;
        ex_trap_valid_i   = 1'b0;
        tcmp_trap_valid_i = 1'b0;
        soft_trap_valid_i = 1'b0;
    endtask

    // Check stall at the negedge, then advance to just after the next posedge.
    task automatic cyc(input logic exp_stall, input string name);
        @(negedge clk);
        total++;
        if (trap_stall_o !== exp_stall) begin
            bad++;
            $display("FAIL %s: stall=%0b required %0b", name, trap_stall_o, exp_stall);
        end
        @(posedge clk);
        #1;
    endtask

    // Accept cycle with current inputs, then five busy cycles, then one idle.
    task automatic run_trap(input string name);
        cyc(1'b1, name);
        clear_in();
        repeat (5) cyc(1'b1, name);
        cyc(1'b0, name);
    endtask

    task automatic run_mret(input string name);
        cyc(1'b1, name);
        clear_in();
        repeat (2) cyc(1'b1, name);
        cyc(1'b0, name);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_in();
        inst_pc_i      = 32'd0;
        next_pc_i      = 32'd0;
        inst_i         = 32'd0;
        mstatus_MIE3_i = 1'b0;
        mepc_i         = 32'd0;
        csr_mstatus    = 32'h88;
        csr_mtvec      = 32'h201;
        rst_n          = 1'b0;
        #22;
        total++;
        if (trap_csr_we_o !== 1'b0 || trap_csr_addr_o !== 12'd0 || trap_csr_wdata_o !== 32'd0 ||
            trap_stall_o !== 1'b0 || trap_jump_o !== 1'b0 || trap_jump_addr_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_outs: we=%0b addr=%h wd=%h st=%0b j=%0b ja=%h, required all 0",
                     trap_csr_we_o, trap_csr_addr_o, trap_csr_wdata_o, trap_stall_o,
                     trap_jump_o, trap_jump_addr_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, "idle_after_reset");

        // 1: illegal instruction
        hx_valid_i = 1'b1; inst_illegal_i = 1'b1; inst_pc_i = 32'h100; inst_i = 32'hFFFF_FFFF;
        push_trap(32'h100, 32'd2, 32'hFFFF_FFFF, 32'h80, 32'h200);
        run_trap("illegal");

        // ebreak with direct-mode mtvec
        csr_mtvec = 32'h1000; csr_mstatus = 32'h08;
        hx_valid_i = 1'b1; inst_ebreak_i = 1'b1; inst_pc_i = 32'h120;
        push_trap(32'h120, 32'd3, 32'h120, 32'h80, 32'h1000);
        run_trap("ebreak");

        // 2: timer interrupt, vectored
        csr_mtvec = 32'h201; csr_mstatus = 32'h88; mstatus_MIE3_i = 1'b1;
        hx_valid_i = 1'b1; tcmp_trap_valid_i = 1'b1; next_pc_i = 32'h44; inst_pc_i = 32'h40;
        push_trap(32'h44, 32'h8000_0007, 32'd0, 32'h80, 32'h21C);
        run_trap("timer_irq");

        // software interrupt with direct-mode mtvec: no vector offset
        csr_mtvec = 32'h1000;
        hx_valid_i = 1'b1; soft_trap_valid_i = 1'b1; next_pc_i = 32'h84;
        push_trap(32'h84, 32'h8000_0003, 32'd0, 32'h80, 32'h1000);
        run_trap("soft_irq_direct");

        // 3a: all three interrupts
        csr_mtvec = 32'h201;
        hx_valid_i = 1'b1; ex_trap_valid_i = 1'b1; soft_trap_valid_i = 1'b1;
        tcmp_trap_valid_i = 1'b1; next_pc_i = 32'h204;
        push_trap(32'h204, 32'h8000_000B, 32'd0, 32'h80, 32'h22C);
        run_trap("irq_priority");

        // 3b: ecall beats interrupts
        hx_valid_i = 1'b1; ex_trap_valid_i = 1'b1; soft_trap_valid_i = 1'b1;
        tcmp_trap_valid_i = 1'b1; inst_ecall_i = 1'b1; inst_pc_i = 32'h300; next_pc_i = 32'h304;
        push_trap(32'h300, 32'd11, 32'd0, 32'h80, 32'h200);
        run_trap("ecall_over_irq");

        // 4: mret
        csr_mstatus = 32'h80; mepc_i = 32'h44;
        hx_valid_i = 1'b1; inst_mret_i = 1'b1;
        push_w(A_MSTATUS, 32'h88);
        push_j(12'h000, 32'h44);
        run_mret("mret");

        // mret with MPIE=0 and misaligned mepc
        csr_mstatus = 32'h00; mepc_i = 32'h47;
        hx_valid_i = 1'b1; inst_mret_i = 1'b1;
        push_w(A_MSTATUS, 32'h80);
        push_j(12'h000, 32'h44);
        run_mret("mret_misaligned");

        // 5: IRQ with MIE=0, and event without hx_valid
        csr_mstatus = 32'h88; mstatus_MIE3_i = 1'b0;
        hx_valid_i = 1'b1; ex_trap_valid_i = 1'b1;
        cyc(1'b0, "irq_masked");
        clear_in();
        inst_illegal_i = 1'b1;
        cyc(1'b0, "no_hx_valid");
        clear_in();

        // 5b: IRQ held during a busy sequence is taken on the first IDLE cycle
        mstatus_MIE3_i = 1'b1;
        hx_valid_i = 1'b1; inst_illegal_i = 1'b1; inst_pc_i = 32'h500; inst_i = 32'h1234_5678;
        next_pc_i = 32'h504;
        push_trap(32'h500, 32'd2, 32'h1234_5678, 32'h80, 32'h200);
        push_trap(32'h504, 32'h8000_0007, 32'd0, 32'h80, 32'h21C);
        cyc(1'b1, "busy_accept");
        inst_illegal_i = 1'b0; tcmp_trap_valid_i = 1'b1;
        repeat (5) cyc(1'b1, "busy_hold");
        cyc(1'b1, "irq_after_busy");
        clear_in();
        repeat (5) cyc(1'b1, "irq_after_busy_seq");
        cyc(1'b0, "irq_after_busy_idle");

        // 6: reset in the middle of a sequence
        hx_valid_i = 1'b1; ex_trap_valid_i = 1'b1; next_pc_i = 32'h600;
        push_w(A_MEPC, 32'h600);
        cyc(1'b1, "rst_accept");
        clear_in();
        cyc(1'b1, "rst_mepc");
        rst_n = 1'b0;
        #1;
        total++;
        if (trap_csr_we_o !== 1'b0 || trap_csr_addr_o !== 12'd0 || trap_csr_wdata_o !== 32'd0 ||
            trap_stall_o !== 1'b0 || trap_jump_o !== 1'b0 || trap_jump_addr_o !== 32'd0) begin
            bad++;
            $display("FAIL midseq_reset: we=%0b addr=%h wd=%h st=%0b j=%0b ja=%h, required all 0",
                     trap_csr_we_o, trap_csr_addr_o, trap_csr_wdata_o, trap_stall_o,
                     trap_jump_o, trap_jump_addr_o);
        end
        repeat (2) cyc(1'b0, "in_reset");
        rst_n = 1'b1;
        cyc(1'b0, "after_reset_idle");
        hx_valid_i = 1'b1; inst_ecall_i = 1'b1; inst_pc_i = 32'h700;
        push_trap(32'h700, 32'd11, 32'd0, 32'h80, 32'h200);
        run_trap("after_reset_ecall");

        repeat (2) cyc(1'b0, "drain");
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_txn: %0d expected transactions not seen, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
